// File: rtl/fpu_arbiter.sv
// fpu_arbiter: shares one FPU between NUM_REQ requesters.
//   Round-robin grant in IDLE, operands latched and held on the FPU inputs,
//   result captured FPU_LATENCY edges after the grant and returned with an ID.
// Ports:
//   clock, reset            - clock, asynchronous active-low reset
//   req_valid/req_ready     - per-requester handshake (at most one ready)
//   req_op_a/req_op_b       - flattened 32-bit operands, requester i at [32i+31:32i]
//   fpu_op_a/fpu_op_b       - operands to the FPU, stable until the next grant
//   fpu_data_in/status_in   - FPU result and status
//   resp_valid/resp_ready   - result handshake; resp_id/data/status held in RESP
//   busy                    - high whenever not IDLE
module fpu_arbiter #(
  parameter int unsigned NUM_REQ     = 4,
  parameter int unsigned ID_W        = 2,
  parameter int unsigned FPU_LATENCY = 4
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [NUM_REQ-1:0]      req_valid,
  output logic [NUM_REQ-1:0]      req_ready,
  input  logic [NUM_REQ*32-1:0]   req_op_a,
  input  logic [NUM_REQ*32-1:0]   req_op_b,
  output logic [31:0]             fpu_op_a,
  output logic [31:0]             fpu_op_b,
  input  logic [31:0]             fpu_data_in,
  input  logic [3:0]              fpu_status_in,
  output logic                    resp_valid,
  input  logic                    resp_ready,
  output logic [ID_W-1:0]         resp_id,
  output logic [31:0]             resp_data,
  output logic [3:0]              resp_status,
  output logic                    busy
);

  localparam int unsigned CNT_W = $clog2(FPU_LATENCY + 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [CNT_W-1:0] r_cnt;
  logic [ID_W-1:0]  r_last;
  logic [ID_W-1:0]  w_win;
  logic [ID_W-1:0]  w_cand;
  logic             w_found;
  logic             w_hs;
  logic [31:0]      r_op_a;
  logic [31:0]      r_op_b;
  logic             r_resp_valid;
  logic [ID_W-1:0]  r_resp_id;
  logic [31:0]      r_resp_data;
  logic [3:0]       r_resp_status;
  logic [31:0]      w_op_a [NUM_REQ];
  logic [31:0]      w_op_b [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign w_op_a[g] = req_op_a[32*g +: 32];
    assign w_op_b[g] = req_op_b[32*g +: 32];
  end

  // Circular search starting just after the last grant; first valid wins.
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    w_cand  = '0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      w_cand = ID_W'((r_last + k) % NUM_REQ);
      if (!w_found && req_valid[w_cand]) begin
        w_found = 1'b1;
        w_win   = w_cand;
      end
    end
  end

  // The winner is always valid, so a grant in IDLE is a handshake.
  assign w_hs = (r_state == ST_IDLE) && w_found;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next    = r_state;
    req_ready = '0;
    busy      = 1'b1;
    case (r_state)
      ST_IDLE: begin
        busy = 1'b0;
        // Gated with reset so ready reads zero while reset is asserted.
        if (w_found && reset) req_ready = NUM_REQ'(1) << w_win;
        if (w_hs) w_next = ST_WAIT;
      end
      ST_WAIT: if (r_cnt == CNT_W'(1)) w_next = ST_RESP;
      ST_RESP: if (resp_ready) w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_cnt         <= '0;
      r_last        <= ID_W'(NUM_REQ - 1);
      r_op_a        <= '0;
      r_op_b        <= '0;
      r_resp_valid  <= 1'b0;
      r_resp_id     <= '0;
      r_resp_data   <= '0;
      r_resp_status <= '0;
    end else begin
      if (w_hs) begin
        r_op_a    <= w_op_a[w_win];
        r_op_b    <= w_op_b[w_win];
        r_resp_id <= w_win;
        r_last    <= w_win;
        r_cnt     <= CNT_W'(FPU_LATENCY);
      end
      if (r_state == ST_WAIT) begin
        r_cnt <= r_cnt - CNT_W'(1);
        if (r_cnt == CNT_W'(1)) begin
          r_resp_data   <= fpu_data_in;
          r_resp_status <= fpu_status_in;
          r_resp_valid  <= 1'b1;
        end
      end
      if (r_state == ST_RESP && resp_ready) r_resp_valid <= 1'b0;
    end
  end

  assign fpu_op_a    = r_op_a;
  assign fpu_op_b    = r_op_b;
  assign resp_valid  = r_resp_valid;
  assign resp_id     = r_resp_id;
  assign resp_data   = r_resp_data;
  assign resp_status = r_resp_status;

endmodule

// File: doc/fpu_arbiter.md
Name: fpu_arbiter

Overview:
- Shares one FPU instance between NUM_REQ requesters using round-robin arbitration and per-requester valid/ready handshakes.
- Accepts an operand pair (op A, op B) from the winning requester and drives it onto the FPU inputs, holding it stable.
- Waits a fixed FPU_LATENCY cycles, captures the FPU data and status outputs, and returns them to the originating requester with an ID tag.
- Sits between the requesting units and the FPU. Only one operation is in flight at a time; there is no pipelining.

Parameters:
- NUM_REQ, 4, number of requesters; legal range 2..8.
- ID_W, 2, requester ID width; must equal ceil(log2(NUM_REQ)).
- FPU_LATENCY, 4, number of clock edges from operand drive to a valid FPU result; must be at least 1.

Ports:
- clock  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- req_valid  in  NUM_REQ  per-requester request valid.
- req_ready  out  NUM_REQ  per-requester accept; at most one bit high at a time.
- req_op_a  in  NUM_REQ*32  flattened op A; requester i occupies bits [32i+31:32i].
- req_op_b  in  NUM_REQ*32  flattened op B; same packing as req_op_a.
- fpu_op_a  out  32  operand A to FPU op_A_in.
- fpu_op_b  out  32  operand B to FPU op_B_in.
- fpu_data_in  in  32  FPU data_out.
- fpu_status_in  in  4  FPU status_out.
- resp_valid  out  1  result valid.
- resp_ready  in  1  result consumer accept.
- resp_id  out  ID_W  index of the requester that owns the result.
- resp_data  out  32  captured FPU result.
- resp_status  out  4  captured FPU status.
- busy  out  1  high in every state other than IDLE.

Behaviour:
- Operand format is fixed: 1 sign bit, 6-bit exponent with bias 31, 25-bit mantissa. The block never interprets operands or results; they pass through unmodified.
- Reset (reset = 0, asynchronous) drives the following to zero: state = IDLE, req_ready, fpu_op_a, fpu_op_b, resp_valid, resp_id, resp_data, resp_status, busy, and the wait counter. The last-grant pointer resets to NUM_REQ-1, so requester 0 has first priority.
- FSM states:
  - IDLE -> WAIT on a handshake.
  - WAIT -> RESP when the wait counter expires.
  - RESP -> IDLE when resp_valid and resp_ready are both high.
- Arbitration (IDLE only):
  - The winner w is the first requester with req_valid set, searching circularly from last_grant+1.
  - req_ready[w] is driven combinationally high for that winner only, in IDLE only; it is 0 in all other states.
  - A handshake occurs on a rising edge where req_valid[w] and req_ready[w] are both high.
- On the handshake edge:
  - fpu_op_a and fpu_op_b are loaded from requester w's slices.
  - resp_id is set to w; last_grant is set to w.
  - The wait counter loads FPU_LATENCY; state moves to WAIT.
- Operand hold: fpu_op_a and fpu_op_b stay constant from the handshake edge until the next handshake, including through RESP and IDLE.
- WAIT:
  - The counter decrements on each edge.
  - On the edge where the counter equals 1, fpu_data_in and fpu_status_in are captured into resp_data and resp_status, resp_valid is set, and state moves to RESP.
  - Result: resp_valid rises exactly FPU_LATENCY edges after the handshake edge.
- RESP:
  - resp_valid, resp_id, resp_data and resp_status are held until an edge with resp_ready = 1. That edge clears resp_valid and returns the FSM to IDLE.
  - If resp_ready is high on the same edge resp_valid rises, it takes effect only on the following edge, so resp_valid is always high for at least 1 cycle.
- Back-to-back operation: a new grant can occur in IDLE on the cycle immediately after the response is accepted. The minimum period is FPU_LATENCY+2 cycles per operation.
- Fairness: with all requesters continuously valid, grants follow the order 0, 1, 2, ..., NUM_REQ-1, 0, ...
- Bandwidth: a requester that drops req_valid loses no bandwidth to the others; it is simply skipped.
- Requester obligation: req_op_a and req_op_b must be stable while req_valid is high and no handshake has occurred. No other requirement is placed on requesters.
- Requests raised or dropped while the block is busy have no effect until the FSM returns to IDLE.
- Reset mid-operation: the in-flight operation and its result are discarded. A requester that keeps req_valid high is re-arbitrated after reset, starting from requester 0 priority.

Test Plan:
- Single requester: req 0 sends 0x3E000000 + 0x3E000000 (1.0+1.0). Check resp_valid exactly 4 edges after the handshake, resp_id=0, resp_data=0x40000000 (2.0), with status passed through.
- Requester 1 sends 0x40000000 + 0x42000000 (2.0+4.0) and requester 2 sends 0x3F000000 + 0x3C000000 (1.5+0.5), both valid in the same cycle.
  - Requester 1 is granted first and returns 0x43000000 (6.0).
  - Requester 2 is then granted and returns 0x40000000.
  - req_ready is never high for both in the same cycle.
- All 4 requesters held valid for 8 operations: grant order is 0,1,2,3,0,1,2,3, and each response carries the correct resp_id.
  - Include req 3 sending 0x3E000000 + 0xBE000000 (1.0 + -1.0), which must return resp_data=0x00000000.
- Backpressure: hold resp_ready=0 for 10 cycles in RESP.
  - resp_* stays stable, busy=1, all req_ready=0.
  - After resp_ready=1 for one edge: resp_valid=0 and the FSM is in IDLE on the next cycle.
- Reset pulse of 1 cycle while in WAIT: all outputs go to zero immediately (asynchronously). After release, a still-valid requester 2 (0x3E000000 + 0x00000000) is granted and returns 0x3E000000.
- Operand hold check: after the handshake, change req_op_a/req_op_b of the granted requester. fpu_op_a and fpu_op_b must stay unchanged until the next handshake.
